// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: framing watchdog, config shadowing, error-tagged byte FIFO
//
// Ports:
//   clk, rst                  clock and asynchronous active-low reset
//   RX_IN                     serial line (same net as the receiver input)
//   P_DATA, data_valid,       receiver byte and its done pulse
//   parity_error, stop_error  receiver error strobes
//   prescale, PAR_EN,         active receiver configuration
//   parity_type
//   cfg_we, cfg_prescale,     configuration write port
//   cfg_par_en,
//   cfg_parity_type
//   cfg_pending, cfg_err      write waiting for idle line / write rejected pulse
//   m_valid, m_ready,         first-word-fall-through FIFO head with error flags
//   m_data, m_perr, m_serr
//   fifo_level                FIFO occupancy 0..DEPTH
//   cnt_clr, drop_cnt,        counter clear, lost-frame and overrun counters
//   ovr_cnt
module uart_rx_ctrl #(
    parameter int DEPTH        = 8,
    parameter int DEF_PRESCALE = 8,
    parameter int MIN_PRESCALE = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       RX_IN,
    input  logic [7:0]                 P_DATA,
    input  logic                       data_valid,
    input  logic                       parity_error,
    input  logic                       stop_error,
    output logic [5:0]                 prescale,
    output logic                       PAR_EN,
    output logic                       parity_type,
    input  logic                       cfg_we,
    input  logic [5:0]                 cfg_prescale,
    input  logic                       cfg_par_en,
    input  logic                       cfg_parity_type,
    output logic                       cfg_pending,
    output logic                       cfg_err,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [7:0]                 m_data,
    output logic                       m_perr,
    output logic                       m_serr,
    output logic [$clog2(DEPTH):0]     fifo_level,
    input  logic                       cnt_clr,
    output logic [7:0]                 drop_cnt,
    output logic [7:0]                 ovr_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FRAME     = 2'd1,
        WAIT_HIGH = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [9:0]  timer, timer_d;
    logic        perr_acc, perr_d;
    logic        serr_acc, serr_d;
    logic        push_req;
    logic        drop_ev;
    logic [9:0]  push_word;
    logic [3:0]  frame_bits;
    logic [9:0]  tmr_load;

    // Shadow configuration, applied only between frames
    logic [5:0]  sh_prescale;
    logic        sh_par_en;
    logic        sh_parity_type;
    logic        cfg_bad;
    logic        cfg_ok;
    logic        cfg_apply;

    // FIFO storage: {perr, serr, data}
    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [9:0]    head;
    logic          full;
    logic          do_push;
    logic          do_pop;
    logic          ovr_ev;

    // Frame window: start + 8 data + optional parity + stop, plus one bit of slack
    assign frame_bits = PAR_EN ? 4'd12 : 4'd11;
    assign tmr_load   = 10'(frame_bits) * 10'(prescale) - 10'd1;
    assign push_word  = {perr_acc | parity_error, serr_acc | stop_error, P_DATA};

    always_comb begin
        state_d  = state;
        timer_d  = timer;
        perr_d   = perr_acc;
        serr_d   = serr_acc;
        push_req = 1'b0;
        drop_ev  = 1'b0;
        case (state)
            IDLE: begin
                if (!RX_IN) begin
                    state_d = FRAME;
                    timer_d = tmr_load;
                    perr_d  = 1'b0;
                    serr_d  = 1'b0;
                end
            end
            FRAME: begin
                timer_d = timer - 10'd1;
                perr_d  = perr_acc | parity_error;
                serr_d  = serr_acc | stop_error;
                // A completed byte wins over a simultaneous timeout
                if (data_valid) begin
                    push_req = 1'b1;
                    state_d  = IDLE;
                end else if (timer == 10'd0) begin
                    drop_ev = 1'b1;
                    // A line still held low is a break: wait for it to rise before re-arming
                    state_d = RX_IN ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (RX_IN) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            timer    <= 10'd0;
            perr_acc <= 1'b0;
            serr_acc <= 1'b0;
        end else begin
            state    <= state_d;
            timer    <= timer_d;
            perr_acc <= perr_d;
            serr_acc <= serr_d;
        end
    end

    assign cfg_bad   = cfg_we && (cfg_prescale < 6'(MIN_PRESCALE));
    assign cfg_ok    = cfg_we && !cfg_bad;
    assign cfg_apply = cfg_pending && (state == IDLE) && RX_IN;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescale       <= 6'(DEF_PRESCALE);
            PAR_EN         <= 1'b0;
            parity_type    <= 1'b0;
            sh_prescale    <= 6'(DEF_PRESCALE);
            sh_par_en      <= 1'b0;
            sh_parity_type <= 1'b0;
            cfg_pending    <= 1'b0;
            cfg_err        <= 1'b0;
        end else begin
            cfg_err <= cfg_bad;
            if (cfg_apply) begin
                prescale    <= sh_prescale;
                PAR_EN      <= sh_par_en;
                parity_type <= sh_parity_type;
            end
            if (cfg_ok) begin
                sh_prescale    <= cfg_prescale;
                sh_par_en      <= cfg_par_en;
                sh_parity_type <= cfg_parity_type;
            end
            // A write landing on the apply edge stays pending for the next idle edge
            if (cfg_ok) begin
                cfg_pending <= 1'b1;
            end else if (cfg_apply) begin
                cfg_pending <= 1'b0;
            end
        end
    end

    assign full    = (fifo_level == LW'(DEPTH));
    assign m_valid = (fifo_level != '0);
    assign do_pop  = m_valid && m_ready;
    assign do_push = push_req && (!full || do_pop);
    assign ovr_ev  = push_req && full && !do_pop;
    assign head    = mem[rd_ptr];
    assign m_data  = m_valid ? head[7:0] : 8'd0;
    assign m_serr  = m_valid ? head[8] : 1'b0;
    assign m_perr  = m_valid ? head[9] : 1'b0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= 8'd0;
            ovr_cnt  <= 8'd0;
        end else if (cnt_clr) begin
            drop_cnt <= 8'd0;
            ovr_cnt  <= 8'd0;
        end else begin
            if (drop_ev && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (ovr_ev && (ovr_cnt != 8'hFF)) begin
                ovr_cnt <= ovr_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard testbench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RX_IN = 1'b1;
    logic [7:0] P_DATA = 8'd0;
    logic       data_valid = 1'b0;
    logic       parity_error = 1'b0;
    logic       stop_error = 1'b0;
    logic [5:0] prescale;
    logic       PAR_EN;
    logic       parity_type;
    logic       cfg_we = 1'b0;
    logic [5:0] cfg_prescale = 6'd8;
    logic       cfg_par_en = 1'b0;
    logic       cfg_parity_type = 1'b0;
    logic       cfg_pending;
    logic       cfg_err;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_perr;
    logic       m_serr;
    logic [3:0] fifo_level;
    logic       cnt_clr = 1'b0;
    logic [7:0] drop_cnt;
    logic [7:0] ovr_cnt;

    int checks = 0;
    int errors = 0;
    logic [9:0] q[$];

    uart_rx_ctrl #(.DEPTH(8), .DEF_PRESCALE(8), .MIN_PRESCALE(4)) dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .P_DATA(P_DATA),
        .data_valid(data_valid), .parity_error(parity_error), .stop_error(stop_error),
        .prescale(prescale), .PAR_EN(PAR_EN), .parity_type(parity_type),
        .cfg_we(cfg_we), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en),
        .cfg_parity_type(cfg_parity_type), .cfg_pending(cfg_pending), .cfg_err(cfg_err),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_perr(m_perr),
        .m_serr(m_serr), .fifo_level(fifo_level), .cnt_clr(cnt_clr),
        .drop_cnt(drop_cnt), .ovr_cnt(ovr_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted head is compared against the oldest expected entry
    always @(negedge clk) begin
        if (rst && m_valid && m_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL monitor_unexpected: got perr=%0b serr=%0b data=%02h, nothing expected",
                         m_perr, m_serr, m_data);
            end else begin
                logic [9:0] exp_w;
                exp_w = q.pop_front();
                if ({m_perr, m_serr, m_data} !== exp_w) begin
                    errors++;
                    $display("FAIL monitor_head: got perr=%0b serr=%0b data=%02h, expected perr=%0b serr=%0b data=%02h",
                             m_perr, m_serr, m_data, exp_w[9], exp_w[8], exp_w[7:0]);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Start bit edge, optional early parity strobe, gap, then the byte-done pulse
    task automatic send_frame(input logic [7:0] d, input bit pe, input bit se,
                              input int gap, input bit exp_push, input bit rdy);
        RX_IN = 1'b0;
        cyc(1);
        RX_IN = 1'b1;
        if (pe) begin
            parity_error = 1'b1;
            cyc(1);
            parity_error = 1'b0;
        end
        cyc(gap);
        P_DATA     = d;
        data_valid = 1'b1;
        stop_error = se;
        if (rdy) m_ready = 1'b1;
        if (exp_push) q.push_back({pe, se, d});
        cyc(1);
        data_valid = 1'b0;
        stop_error = 1'b0;
        if (rdy) m_ready = 1'b0;
        cyc(1);
    endtask

    task automatic cfg_write(input logic [5:0] p, input bit pe, input bit pt);
        cfg_prescale    = p;
        cfg_par_en      = pe;
        cfg_parity_type = pt;
        cfg_we          = 1'b1;
        cyc(1);
        cfg_we          = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(3);
        chk("rst_prescale", prescale, 8);
        chk("rst_par_en", PAR_EN, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_level", fifo_level, 0);
        rst = 1'b1;
        cyc(2);
        chk("rst_pending", cfg_pending, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_ovr", ovr_cnt, 0);

        // Plain frame, held in FIFO
        send_frame(8'hA5, 1'b0, 1'b0, 5, 1'b1, 1'b0);
        chk("t1_valid", m_valid, 1);
        chk("t1_data", m_data, 8'hA5);
        chk("t1_perr", m_perr, 0);
        chk("t1_serr", m_serr, 0);
        chk("t1_level", fifo_level, 1);
        m_ready = 1'b1;
        cyc(2);

        // Enable parity while idle: applied one cycle after the write
        cfg_write(6'd8, 1'b1, 1'b0);
        chk("t2_pending_set", cfg_pending, 1);
        chk("t2_par_en_before", PAR_EN, 0);
        cyc(1);
        chk("t2_par_en_after", PAR_EN, 1);
        chk("t2_pending_clr", cfg_pending, 0);
        send_frame(8'h3C, 1'b1, 1'b0, 4, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 4, 1'b1, 1'b0);

        // Break: line low for a long time, only one drop and no re-arm
        RX_IN = 1'b0;
        cyc(96);
        chk("t2_no_drop_early", drop_cnt, 0);
        cyc(1);
        chk("t2_drop_once", drop_cnt, 1);
        cyc(200);
        chk("t2_break_hold", drop_cnt, 1);
        RX_IN = 1'b1;
        cyc(2);
        cfg_write(6'd8, 1'b0, 1'b0);
        cyc(2);
        chk("t2_par_off", PAR_EN, 0);

        // Overrun: nine frames into eight entries
        m_ready = 1'b0;
        chk("t3_empty", fifo_level, 0);
        for (int i = 0; i < 9; i++) begin
            send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 3, (i < 8), 1'b0);
        end
        chk("t3_level", fifo_level, 8);
        chk("t3_ovr", ovr_cnt, 1);
        chk("t3_head", m_data, 8'h10);
        m_ready = 1'b1;
        cyc(10);
        chk("t3_drained", fifo_level, 0);

        // Full FIFO with a pop in the push cycle: no overrun
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_frame(8'h20 + 8'(i), 1'b0, 1'b0, 3, 1'b1, 1'b0);
        end
        send_frame(8'h28, 1'b0, 1'b0, 3, 1'b1, 1'b1);
        chk("t3b_level", fifo_level, 8);
        chk("t3b_ovr", ovr_cnt, 1);
        m_ready = 1'b1;
        cyc(10);

        // Config write mid-frame waits for idle line
        RX_IN = 1'b0;
        cyc(1);
        RX_IN = 1'b1;
        cfg_write(6'd16, 1'b0, 1'b0);
        chk("t4_pending", cfg_pending, 1);
        chk("t4_hold", prescale, 8);
        cyc(5);
        P_DATA = 8'h77;
        data_valid = 1'b1;
        q.push_back({2'b00, 8'h77});
        cyc(1);
        data_valid = 1'b0;
        chk("t4_hold_end", prescale, 8);
        cyc(1);
        chk("t4_applied", prescale, 16);
        chk("t4_pending_clr", cfg_pending, 0);
        cfg_write(6'd2, 1'b1, 1'b1);
        chk("t4_err_pulse", cfg_err, 1);
        chk("t4_rej_prescale", prescale, 16);
        chk("t4_rej_pending", cfg_pending, 0);
        cyc(1);
        chk("t4_err_clr", cfg_err, 0);
        chk("t4_rej_par", PAR_EN, 0);

        // Timer boundary at prescale 16: window 176 cycles
        send_frame(8'hC3, 1'b0, 1'b0, 175, 1'b1, 1'b0);
        chk("t5_same_cycle_drop", drop_cnt, 1);
        send_frame(8'hE1, 1'b0, 1'b0, 176, 1'b0, 1'b0);
        chk("t5_late_drop", drop_cnt, 2);
        cyc(3);
        chk("t5_late_level", fifo_level, 0);
        cnt_clr = 1'b1;
        cyc(1);
        cnt_clr = 1'b0;
        chk("t5_clr_drop", drop_cnt, 0);
        chk("t5_clr_ovr", ovr_cnt, 0);

        // Asynchronous reset mid-frame
        m_ready = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        RX_IN = 1'b0;
        cyc(1);
        cfg_write(6'd20, 1'b1, 1'b1);
        chk("t6_pending_pre", cfg_pending, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_prescale", prescale, 8);
        chk("t6_pending", cfg_pending, 0);
        chk("t6_m_valid", m_valid, 0);
        chk("t6_m_data", m_data, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_par_en", PAR_EN, 0);
        RX_IN = 1'b1;
        cyc(2);
        rst = 1'b1;
        cyc(3);
        chk("t6_post_prescale", prescale, 8);
        chk("t6_post_level", fifo_level, 0);
        m_ready = 1'b1;

        for (int i = 0; i < 50 && q.size() != 0; i++) cyc(1);
        chk("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Controller for the UART receive datapath. Owns its runtime configuration: prescale, PAR_EN and parity_type.
- Frames every reception by watching RX_IN plus data_valid / parity_error / stop_error from the receiver top.
- Buffers received bytes with per-byte error flags in a FIFO, drained by a valid/ready consumer.
- Detects lost frames (no data_valid within the frame window) and FIFO overruns. Counts both.

Parameters:
- DEPTH, 8: FIFO entries (power of 2, ≥2).
- DEF_PRESCALE, 8: prescale value loaded at reset.
- MIN_PRESCALE, 4: smallest accepted prescale; smaller writes are rejected.

Ports:
- clk  in  1  clock (same domain as the receiver)
- rst  in  1  asynchronous, active-low reset
- RX_IN  in  1  serial line, same net that feeds the receiver
- P_DATA  in  8  receiver parallel data
- data_valid  in  1  receiver byte-done pulse
- parity_error  in  1  receiver parity error
- stop_error  in  1  receiver stop error
- prescale  out  6  active prescale, to the receiver
- PAR_EN  out  1  active parity enable, to the receiver
- parity_type  out  1  active parity type, to the receiver
- cfg_we  in  1  config write strobe
- cfg_prescale  in  6  requested prescale
- cfg_par_en  in  1  requested PAR_EN
- cfg_parity_type  in  1  requested parity_type
- cfg_pending  out  1  a write is waiting for idle
- cfg_err  out  1  one-cycle pulse: write rejected
- m_valid  out  1  FIFO head valid
- m_ready  in  1  consumer accepts head
- m_data  out  8  head byte
- m_perr  out  1  head parity error flag
- m_serr  out  1  head stop error flag
- fifo_level  out  log2(DEPTH)+1  occupancy
- cnt_clr  in  1  synchronous clear of both counters
- drop_cnt  out  8  lost frames, saturating
- ovr_cnt  out  8  overrun drops, saturating

Behaviour:
- Reset (rst=0, async):
  - prescale=DEF_PRESCALE, PAR_EN=0, parity_type=0.
  - State IDLE. FIFO empty: m_valid=0, fifo_level=0, m_data/m_perr/m_serr=0.
  - Counters 0. cfg_pending=0, cfg_err=0.
  - Reset mid-frame discards the frame and any pending config.
- FSM states: IDLE, FRAME, WAIT_HIGH.
  - IDLE→FRAME when RX_IN=0 at a clk edge.
    - timer loads (10+PAR_EN+1)*prescale-1 (10-bit, unsigned).
    - Error accumulators perr_acc/serr_acc cleared.
  - FRAME:
    - timer decrements each cycle.
    - perr_acc|=parity_error; serr_acc|=stop_error.
  - FRAME, data_valid=1:
    - Push {perr_acc|parity_error, serr_acc|stop_error, P_DATA}.
    - Next state IDLE.
  - FRAME, timer==0 and data_valid=0:
    - drop_cnt+1 (saturate at 255).
    - Next state WAIT_HIGH if RX_IN=0, else IDLE.
  - data_valid has priority over the timeout in the same cycle.
  - data_valid outside FRAME is ignored.
  - WAIT_HIGH→IDLE when RX_IN=1 (break handling: no re-arm while the line is held low).
- Config:
  - cfg_we with cfg_prescale<MIN_PRESCALE: write ignored, cfg_err=1 next cycle, pending unchanged.
  - Valid write latches a shadow and sets cfg_pending. A newer write overwrites the shadow.
  - Shadow is applied to the outputs on the first edge where state=IDLE and RX_IN=1. cfg_pending clears on that same edge.
  - A write accepted while already IDLE with RX_IN=1 takes effect one cycle after cfg_we.
  - Outputs never change while in FRAME or WAIT_HIGH.
- FIFO:
  - First-word-fall-through; m_data/m_perr/m_serr are valid whenever m_valid=1.
  - Pop on m_valid&&m_ready.
  - Push while full with no pop: entry discarded, ovr_cnt+1 (saturating).
  - Push and pop in the same cycle when full: both succeed, level unchanged, no overrun.
  - Push and pop when empty: push only.
  - Pointers wrap modulo DEPTH.
  - fifo_level counts 0..DEPTH.
- Counters:
  - cnt_clr zeroes both counters.
  - cnt_clr coincident with an increment event: result is 0.

Test Plan:
- Reset, prescale=8, send 0xA5 with correct stop; data_valid pulse → m_valid=1, m_data=0xA5, m_perr=0, m_serr=0, fifo_level=1.
- PAR_EN=1, even parity; send 0x3C with a wrong parity bit → entry 0x3C, m_perr=1. Hold RX_IN low 20 bit-times with no data_valid → drop_cnt=1, state stays WAIT_HIGH until RX_IN rises.
- DEPTH=8, m_ready=0, receive 9 frames → fifo_level=8, ovr_cnt=1, head is frame 1. Repeat with m_ready=1 in the 9th push cycle → ovr_cnt unchanged.
- cfg_we prescale=16 mid-frame → cfg_pending=1, prescale stays 8 until the frame ends and the line is high, then prescale=16, cfg_pending=0. cfg_we prescale=2 → cfg_err pulse, no change.
- data_valid and timer expiry in the same cycle → byte pushed, drop_cnt unchanged. Drive rst low mid-frame → all outputs at reset values immediately.
